// File: rtl/pipeline_pkg.sv
// Definitions shared across the pipeline stages: PC source encodings,
// the bubble instruction and the default reset vector.
package pipeline_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry skid register for the fetch stage. It parks a returned
// instruction word while decode is stalled and presents it first on release.
module if_hold_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] rdata,
  output logic             held_valid,
  output logic [WIDTH-1:0] fetched_instr
);

  logic [WIDTH-1:0] held_instr;

  // clear outranks load: a redirect or a consumed word empties the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_instr <= '0;
    end else if (clear) begin
      held_valid <= 1'b0;
    end else if (load && !held_valid) begin
      held_valid <= 1'b1;
      held_instr <= rdata;
    end
  end

  assign fetched_instr = held_valid ? held_instr : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC, and loads the
// IF/ID register, riding out memory waits and decode stalls without refetching.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic [WIDTH-1:0] JrTarget,
  input  logic [WIDTH-1:0] ImemRdata,
  input  logic             ImemValid,
  output logic [WIDTH-1:0] ImemAddr,
  output logic             ImemReq,
  output logic [WIDTH-1:0] PCAddress,
  output logic [WIDTH-1:0] nextPCAddress,
  output logic [WIDTH-1:0] ID_Instr,
  output logic [WIDTH-1:0] ID_PCPlus4,
  output logic             ID_Valid
);

  logic             redirect;
  logic             held_valid;
  logic             fetch_done;
  logic [WIDTH-1:0] fetched_instr;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;

  assign redirect   = (PCSrc != PCSRC_SEQ);
  assign fetch_done = ImemValid | held_valid;
  assign pc_plus4   = PCAddress + WIDTH'(4);

  // NOTE: always_comb assigns every output a default first so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    target_raw = BranchTarget;
    unique case (pcsrc_e'(PCSrc))
      PCSRC_SEQ: target_raw = BranchTarget;
      PCSRC_BR:  target_raw = BranchTarget;
      PCSRC_J:   target_raw = JumpTarget;
      PCSRC_JR:  target_raw = JrTarget;
      default:   target_raw = BranchTarget;
    endcase
  end

  // Instructions are word aligned, so the low two target bits are dropped.
  assign target = target_raw & ~WIDTH'(3);

  always_comb begin
    nextPCAddress = pc_plus4;
    if (redirect)
      nextPCAddress = target;
    else if (Stall || !fetch_done)
      nextPCAddress = PCAddress;
  end

  if_hold_buffer #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk           (Clk),
    .reset         (Reset),
    .load          (ImemValid),
    .clear         (redirect || !Stall),
    .rdata         (ImemRdata),
    .held_valid    (held_valid),
    .fetched_instr (fetched_instr)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCAddress  <= RESET_PC;
      ID_Instr   <= WIDTH'(NOP_INSTR);
      ID_PCPlus4 <= '0;
      ID_Valid   <= 1'b0;
    end else begin
      PCAddress <= nextPCAddress;
      if (redirect) begin
        ID_Instr <= WIDTH'(NOP_INSTR);
        ID_Valid <= 1'b0;
      end else if (Stall) begin
        ID_Instr <= ID_Instr;
      end else if (fetch_done) begin
        ID_Instr   <= fetched_instr;
        ID_PCPlus4 <= pc_plus4;
        ID_Valid   <= 1'b1;
      end else begin
        ID_Instr <= WIDTH'(NOP_INSTR);
        ID_Valid <= 1'b0;
      end
    end
  end

  assign ImemAddr = PCAddress;
  assign ImemReq  = !Reset && !held_valid;

endmodule
